// File: rtl/sar_scan_seq.sv
// Multi-channel scan sequencer for the synchronous SAR conversion core.
// Selects a channel, holds track/settle, releases the core for 2^k
// conversions, averages the captured codes and hands {channel, code}
// downstream over a valid/ready port.
module sar_scan_seq #(
  parameter int N   = 12,
  parameter int NCH = 4,
  parameter int CHW = 2,
  parameter int TMO = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           cont,
  input  logic [NCH-1:0] ch_mask,
  input  logic [1:0]     avg_log2,
  input  logic [7:0]     settle_cyc,
  output logic           sar_run,
  input  logic [N-1:0]   sar_dq,
  input  logic           sar_last,
  output logic [CHW-1:0] ch_sel,
  output logic           sample,
  output logic [N-1:0]   res_data,
  output logic [CHW-1:0] res_ch,
  output logic           res_valid,
  input  logic           res_ready,
  output logic           busy,
  output logic           tmo_err
);

  localparam int TW = $clog2(TMO + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    CONV   = 3'd2,
    GAP    = 3'd3,
    EMIT   = 3'd4
  } state_t;

  // Lowest enabled channel at index >= from; MSB of the result is "found".
  function automatic logic [CHW:0] first_ch(input logic [NCH-1:0] m, input int from);
    logic [CHW:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i] && (i >= from)) begin
        r = {1'b1, CHW'(i)};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  state_t           state_r, state_n;
  logic [7:0]       scnt_r, scnt_n;
  logic [TW-1:0]    ccnt_r, ccnt_n;
  logic [N+2:0]     acc_r, acc_n;
  logic [3:0]       cnt_r, cnt_n;
  logic [NCH-1:0]   mask_r, mask_n;
  logic [1:0]       avg_r, avg_n;
  logic [7:0]       settle_r, settle_n;
  logic [CHW-1:0]   ch_n;
  logic [N-1:0]     rdata_n;
  logic [CHW-1:0]   rch_n;
  logic             tmo_n;
  logic [N+2:0]     sum_s;
  logic [N+2:0]     shifted_s;
  logic [CHW:0]     first_s;
  logic [CHW:0]     next_s;
  logic [CHW:0]     low_s;

  // Next-state, counter, accumulator and result computation.
  always_comb begin
    state_n   = state_r;
    scnt_n    = scnt_r;
    ccnt_n    = ccnt_r;
    acc_n     = acc_r;
    cnt_n     = cnt_r;
    mask_n    = mask_r;
    avg_n     = avg_r;
    settle_n  = settle_r;
    ch_n      = ch_sel;
    rdata_n   = res_data;
    rch_n     = res_ch;
    tmo_n     = tmo_err;
    sum_s     = acc_r + {3'b000, sar_dq};
    shifted_s = sum_s >> avg_r;
    first_s   = first_ch(ch_mask, 0);
    next_s    = first_ch(mask_r, int'(ch_sel) + 1);
    low_s     = first_ch(mask_r, 0);

    case (state_r)
      IDLE: begin
        if (start && (ch_mask != '0)) begin
          mask_n   = ch_mask;
          avg_n    = avg_log2;
          settle_n = settle_cyc;
          tmo_n    = 1'b0;
          ch_n     = first_s[CHW-1:0];
          scnt_n   = (settle_cyc == 8'd0) ? 8'd1 : settle_cyc;
          acc_n    = '0;
          cnt_n    = 4'd0;
          state_n  = SETTLE;
        end else begin
          state_n = IDLE;
        end
      end
      SETTLE: begin
        if (scnt_r <= 8'd1) begin
          ccnt_n  = '0;
          state_n = CONV;
        end else begin
          scnt_n = scnt_r - 8'd1;
        end
      end
      CONV: begin
        if (sar_last) begin
          acc_n  = sum_s;
          cnt_n  = cnt_r + 4'd1;
          ccnt_n = '0;
          if ((cnt_r + 4'd1) < (4'd1 << avg_r)) begin
            state_n = GAP;
          end else begin
            rdata_n = shifted_s[N-1:0];
            rch_n   = ch_sel;
            state_n = EMIT;
          end
        end else if (ccnt_r == TW'(TMO - 1)) begin
          // Core never finished: abandon the whole scan.
          tmo_n   = 1'b1;
          acc_n   = '0;
          cnt_n   = 4'd0;
          state_n = IDLE;
        end else begin
          ccnt_n = ccnt_r + TW'(1);
        end
      end
      GAP: begin
        ccnt_n  = '0;
        state_n = CONV;
      end
      EMIT: begin
        if (res_ready) begin
          acc_n = '0;
          cnt_n = 4'd0;
          if (next_s[CHW]) begin
            ch_n    = next_s[CHW-1:0];
            scnt_n  = (settle_r == 8'd0) ? 8'd1 : settle_r;
            state_n = SETTLE;
          end else if (cont) begin
            ch_n    = low_s[CHW-1:0];
            scnt_n  = (settle_r == 8'd0) ? 8'd1 : settle_r;
            state_n = SETTLE;
          end else begin
            state_n = IDLE;
          end
        end else begin
          state_n = EMIT;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      scnt_r    <= 8'd0;
      ccnt_r    <= '0;
      acc_r     <= '0;
      cnt_r     <= 4'd0;
      mask_r    <= '0;
      avg_r     <= 2'd0;
      settle_r  <= 8'd0;
      ch_sel    <= '0;
      res_data  <= '0;
      res_ch    <= '0;
      tmo_err   <= 1'b0;
      sample    <= 1'b0;
      sar_run   <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_n;
      scnt_r    <= scnt_n;
      ccnt_r    <= ccnt_n;
      acc_r     <= acc_n;
      cnt_r     <= cnt_n;
      mask_r    <= mask_n;
      avg_r     <= avg_n;
      settle_r  <= settle_n;
      ch_sel    <= ch_n;
      res_data  <= rdata_n;
      res_ch    <= rch_n;
      tmo_err   <= tmo_n;
      sample    <= (state_n == SETTLE);
      sar_run   <= (state_n == CONV);
      res_valid <= (state_n == EMIT);
      busy      <= (state_n != IDLE);
    end
  end

endmodule

// File: doc/sar_scan_seq.md
Name: sar_scan_seq

Overview:
Multi-channel scan sequencer for the synchronous SAR conversion core. It selects an analog input channel and holds track/settle, then releases the SAR core for one or more conversions. It captures the final code on the core's last-cycle strobe, optionally averages 2^k conversions, and delivers {channel, code} over a valid/ready port. It sits between the register/config layer and the SAR core plus input mux.

Parameters:
N, 12, SAR code width (matches SAR core)
NCH, 4, number of input channels
CHW, 2, channel index width (ceil(log2(NCH)))
TMO, 64, max cycles in CONV before timeout (must exceed N+2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  pulse: begin a scan (ignored unless IDLE)
cont  in  1  continuous mode: wrap to first channel after last enabled one
ch_mask  in  NCH  enabled channels; latched at scan start
avg_log2  in  2  samples per result = 2^avg_log2 (1..8); latched at scan start
settle_cyc  in  8  track/settle cycles per channel; latched at scan start
sar_run  out  1  high = SAR core runs; low = core held in reset
sar_dq  in  N  SAR core code
sar_last  in  1  SAR final-cycle strobe; sar_dq is final in this cycle
ch_sel  out  CHW  input mux select
sample  out  1  track switch enable
res_data  out  N  averaged code
res_ch  out  CHW  channel of res_data
res_valid  out  1  result valid
res_ready  in  1  downstream accepts
busy  out  1  scan in progress (state != IDLE)
tmo_err  out  1  sticky conversion-timeout flag, cleared by rst or by next accepted start

Behaviour:
- One clock, clk. Reset is synchronous and active-high (rst). All outputs are 0 on reset. Reset mid-scan aborts on the next edge regardless of state. The FSM goes to IDLE and any pending result is dropped.
- States: IDLE, SETTLE, CONV, GAP, EMIT.
- IDLE: on start=1 with ch_mask!=0, latch the config and select the lowest enabled channel. Go to SETTLE on the next edge with ch_sel=channel, sample=1, and the settle counter loaded. start with ch_mask==0 is ignored; the FSM stays IDLE and tmo_err is unchanged.
- SETTLE: sample=1, sar_run=0. Lasts max(settle_cyc,1) cycles, then go to CONV.
- CONV: sample=0, sar_run=1. On the edge where sar_last=1:
  - accumulate sar_dq into an (N+3)-bit accumulator;
  - increment the sample count;
  - sar_run drops on that same edge.
  - If count < 2^avg_log2, go to GAP. Otherwise go to EMIT.
- The CONV cycle counter resets on every CONV entry. If it reaches TMO without sar_last: set tmo_err, clear the accumulator, go to IDLE. The rest of the scan is abandoned.
- GAP: exactly 1 cycle with sar_run=0, so the core restarts. Then CONV. There is no re-settle between averaged samples.
- EMIT: res_valid=1, res_data=acc>>avg_log2 (truncated, low N bits), res_ch=current channel. Data and channel stay stable while res_valid=1 and res_ready=0. There is no timeout here; backpressure stalls the scan indefinitely.
- On res_valid&&res_ready: res_valid drops on the next edge and the accumulator and count clear. The FSM then goes to the next higher enabled channel (SETTLE). Past the last enabled channel:
  - cont=1 (sampled at this edge): wrap to the lowest enabled channel;
  - cont=0: go to IDLE.
- res_ready while res_valid=0 is ignored. start while busy is ignored. Config changes while busy take effect at the next scan start.
- Latency, single channel, avg=1, settle=S, core needing C cycles to sar_last: start edge + S SETTLE + C CONV, then res_valid on the following edge.
- Accumulator max = 8*(2^N-1), fits in N+3 bits with no overflow.

Test Plan:
- ch_mask=4'b0101, avg_log2=0, settle_cyc=3, cont=0, stub core returns 0xABC after 13 cycles, res_ready=1 -> two results: ch0 0xABC, then ch2 0xABC; sample high exactly 3 cycles per channel; busy low after the second handshake.
- avg_log2=2, core returns 100,101,102,103 -> one result, res_data=101 (406>>2); sar_run low exactly 1 cycle between conversions.
- res_ready held 0 for 20 cycles in EMIT -> res_valid, res_data and res_ch constant; no sar_run activity; release gives exactly one transfer.
- Stub core never asserts sar_last -> after TMO=64 CONV cycles tmo_err=1, busy=0, no res_valid. The next start clears tmo_err.
- cont=1, ch_mask=4'b1000 -> repeated ch3 results. Dropping cont before a handshake -> IDLE after that result.
- rst=1 asserted mid-CONV and mid-EMIT -> all outputs 0 after one edge. start with ch_mask=0 -> busy stays 0.
